// File: rtl/jtag_driver.sv
// rtl/jtag_driver.sv - command-driven JTAG master walking the TAP from Run-Test/Idle to Run-Test/Idle
module jtag_driver #(
  parameter int CLK_DIV = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IDLE  = 2'b01;
  localparam logic [1:0] OP_IR    = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_RSP} state_t;

  state_t        state, nstate;
  logic [4:0]    cnt, ncnt;
  logic [DW-1:0] div_cnt;
  logic [1:0]    op_r;
  logic [4:0]    len_r;
  logic [31:0]   data_r;
  logic [4:0]    hdr_last;
  logic          fall_edge;
  logic          sample_edge;

  // TMS value for a given position in the walk; RESET and IDLE live entirely in the header phase
  function automatic logic seq_tms(input state_t st, input logic [4:0] c,
                                   input logic [1:0] op, input logic [4:0] len);
    logic v;
    v = 1'b0;
    case (st)
      S_HDR: begin
        case (op)
          OP_RESET: v = (c < 5'd5);
          OP_IDLE:  v = 1'b0;
          OP_IR:    v = (c < 5'd2);
          default:  v = (c == 5'd0);
        endcase
      end
      S_SHIFT: v = (c == len);
      S_TRL:   v = (c == 5'd0);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // TDI carries command data only while shifting
  function automatic logic seq_tdi(input state_t st, input logic [4:0] c, input logic [31:0] d);
    return (st == S_SHIFT) ? d[c] : 1'b0;
  endfunction

  // Last header index per op; IDLE uses the header phase to count its tck pulses
  always_comb begin
    case (op_r)
      OP_RESET: hdr_last = 5'd5;
      OP_IDLE:  hdr_last = len_r;
      OP_IR:    hdr_last = 5'd3;
      default:  hdr_last = 5'd2;
    endcase
  end

  assign fall_edge   = (state == S_HDR || state == S_SHIFT || state == S_TRL) && tck && (div_cnt == DIV_LAST);
  assign sample_edge = (state == S_SHIFT) && tck && (div_cnt == '0);

  // State register: phase and bit position within the phase
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  // Next-state: phases advance only on the sysclk edge that drops tck
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          nstate = S_HDR;
          ncnt   = 5'd0;
        end
      end
      S_HDR: begin
        if (fall_edge) begin
          if (cnt == hdr_last) begin
            nstate = op_r[1] ? S_SHIFT : S_IDLE;
            ncnt   = 5'd0;
          end else begin
            ncnt = cnt + 5'd1;
          end
        end
      end
      S_SHIFT: begin
        if (fall_edge) begin
          if (cnt == len_r) begin
            nstate = S_TRL;
            ncnt   = 5'd0;
          end else begin
            ncnt = cnt + 5'd1;
          end
        end
      end
      S_TRL: begin
        if (fall_edge) begin
          if (cnt == 5'd1) begin
            nstate = S_RSP;
            ncnt   = 5'd0;
          end else begin
            ncnt = cnt + 5'd1;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the phase
  always_comb begin
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RSP);
    busy      = (state != S_IDLE);
  end

  // Pin timing: tck divider, tms/tdi update on tck fall, tdo capture while tck is high
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      op_r     <= 2'b00;
      len_r    <= 5'd0;
      data_r   <= 32'd0;
      rsp_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          tck     <= 1'b0;
          if (cmd_valid) begin
            op_r     <= cmd_op;
            len_r    <= cmd_len;
            data_r   <= cmd_data;
            rsp_data <= 32'd0;
            tms      <= seq_tms(S_HDR, 5'd0, cmd_op, cmd_len);
            tdi      <= 1'b0;
          end
        end
        S_HDR, S_SHIFT, S_TRL: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tck     <= ~tck;
            if (tck) begin
              tms <= seq_tms(nstate, ncnt, op_r, len_r);
              tdi <= seq_tdi(nstate, ncnt, data_r);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (sample_edge) rsp_data[cnt] <= tdo;
        end
        default: ;
      endcase
    end
  end

endmodule
